// File: rtl/seqdet_pkg.sv
// Shared types and next-state function for the "1001" overlapping Moore detector.
package seqdet_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;

    localparam state_t DET_STATE = S4;

    function automatic state_t seqdet_next(state_t st, logic b);
        state_t nx;
        case (st)
            S0:      nx = b ? S1 : S0;
            S1:      nx = b ? S1 : S2;
            S2:      nx = b ? S1 : S3;
            S3:      nx = b ? S4 : S0;
            S4:      nx = b ? S1 : S2;
            default: nx = S0;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/seqdet_rr_arb.sv
// Combinational rotate-priority arbiter: first requester searched from ptr+1 upward, wrapping.
module seqdet_rr_arb #(
    parameter int unsigned NCH = 4,
    localparam int unsigned CW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic           gnt_valid_o,
    output logic [CW-1:0]  gnt_idx_o
);

    int unsigned idx;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        // k = NCH revisits ptr itself last, so the last winner has lowest priority.
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(ptr_i) + k) % NCH;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/seqdet_rr_sched.sv
// One "1001" detection engine time-shared across NCH serial channels by a round-robin arbiter.
// Optional per-channel saturating detection counters under SEQDET_SCHED_CNT_EN.
module seqdet_rr_sched
    import seqdet_pkg::*;
#(
    parameter int unsigned NCH = 4,
    localparam int unsigned CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in_valid_i,
    input  logic [NCH-1:0] in_bit_i,
    output logic [NCH-1:0] in_ready_o,
    input  logic [NCH-1:0] chan_clr_i,
    output logic           det_valid_o,
    output logic [CW-1:0]  det_ch_o
`ifdef SEQDET_SCHED_CNT_EN
    ,
    input  logic [CW-1:0]  cnt_sel_i,
    output logic [7:0]     cnt_out_o
`endif
);

    state_t         st_q [NCH];
    state_t         st_d [NCH];
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] bit_q, bit_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  det_ch_q, det_ch_d;
    logic           det_valid_q, det_valid_d;
    logic           gnt_valid;
    logic [CW-1:0]  gnt_idx;
    state_t         eng_next;

    seqdet_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .req_i       (pend_q),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        pend_d      = pend_q;
        bit_d       = bit_q;
        st_d        = st_q;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        eng_next    = seqdet_next(st_q[gnt_idx], bit_q[gnt_idx]);

        if (gnt_valid) begin
            ptr_d           = gnt_idx;
            pend_d[gnt_idx] = 1'b0;
            // A same-cycle clear suppresses the state update and detection, not the ptr move.
            if (!chan_clr_i[gnt_idx]) begin
                st_d[gnt_idx] = eng_next;
                if (eng_next == DET_STATE) begin
                    det_valid_d = 1'b1;
                    det_ch_d    = gnt_idx;
                end
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (in_valid_i[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                bit_d[i]  = in_bit_i[i];
            end
            if (chan_clr_i[i]) begin
                pend_d[i] = 1'b0;
                st_d[i]   = S0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i] <= S0;
            end
            pend_q      <= '0;
            bit_q       <= '0;
            ptr_q       <= CW'(NCH - 1);
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            st_q        <= st_d;
            pend_q      <= pend_d;
            bit_q       <= bit_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign in_ready_o  = ~pend_q;
    assign det_valid_o = det_valid_q;
    assign det_ch_o    = det_ch_q;

`ifdef SEQDET_SCHED_CNT_EN
    logic [7:0] cnt_q [NCH];
    logic [7:0] cnt_d [NCH];

    always_comb begin
        cnt_d = cnt_q;
        if (det_valid_d && cnt_q[det_ch_d] != 8'hFF) begin
            cnt_d[det_ch_d] = cnt_q[det_ch_d] + 8'd1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (chan_clr_i[i]) begin
                cnt_d[i] = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out_o = cnt_q[cnt_sel_i];
`endif

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Scoreboard bench for seqdet_rr_sched: stimulus pushes expected detection channels,
// a negedge monitor pops and compares them whenever det_valid is seen.
module tb_seqdet_rr_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_bit;
    logic [NCH-1:0] in_ready;
    logic [NCH-1:0] chan_clr;
    logic           det_valid;
    logic [CW-1:0]  det_ch;
    logic [CW-1:0]  cnt_sel;
    logic [7:0]     cnt_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    logic [31:0] seq_a [NCH];
    int          len_a [NCH];
    logic [31:0] det_a [NCH];

    seqdet_rr_sched #(
        .NCH (NCH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_bit_i    (in_bit),
        .in_ready_o  (in_ready),
        .chan_clr_i  (chan_clr),
        .det_valid_o (det_valid),
        .det_ch_o    (det_ch)
`ifdef SEQDET_SCHED_CNT_EN
        ,
        .cnt_sel_i   (cnt_sel),
        .cnt_out_o   (cnt_out)
`endif
    );

`ifndef SEQDET_SCHED_CNT_EN
    assign cnt_out = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every detection pulse must match the next expected channel.
    always @(negedge clk) begin
        if (!reset && det_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_det: got ch %0d expected no detection at %0t",
                         det_ch, $time);
            end else begin
                chk("det_ch", 32'(det_ch), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_vec();
        for (int c = 0; c < NCH; c++) begin
            seq_a[c] = '0;
            len_a[c] = 0;
            det_a[c] = '0;
        end
    endtask

    task automatic drain_and_check(input string name);
        repeat (8) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Offers every channel's next bit whenever it is ready; MSB of seq_a goes first.
    task automatic run_vec(input string name, input int budget);
        int idx[NCH];
        bit drove[NCH];
        int cyc;
        bit done;
        int pos;
        cyc = 0;
        for (int c = 0; c < NCH; c++) begin
            idx[c]   = 0;
            drove[c] = 1'b0;
        end
        while (1) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (drove[c]) chk("ready_low_after_accept", 32'(in_ready[c]), 32'd0);
            end
            done = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (idx[c] < len_a[c]) done = 1'b0;
            end
            if (done) begin
                in_valid = '0;
                break;
            end
            for (int c = 0; c < NCH; c++) begin
                drove[c] = 1'b0;
                if (idx[c] < len_a[c] && in_ready[c]) begin
                    pos         = len_a[c] - 1 - idx[c];
                    in_valid[c] = 1'b1;
                    in_bit[c]   = seq_a[c][pos];
                    if (det_a[c][pos]) exp_q.push_back(c);
                    idx[c]++;
                    drove[c] = 1'b1;
                end else begin
                    in_valid[c] = 1'b0;
                end
            end
            cyc++;
            if (cyc > budget) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got %0d cycles expected at most %0d", name, cyc, budget);
                in_valid = '0;
                break;
            end
        end
        drain_and_check({name, "_pending_dets"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        chan_clr = '0;
        cnt_sel  = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'hF);
        chk("reset_det_valid", 32'(det_valid), 32'd0);
        chk("reset_det_ch", 32'(det_ch), 32'd0);
        reset = 1'b0;

        // Overlap on ch0: 1001001 detects after bits 4 and 7.
        clear_vec();
        seq_a[0] = 32'b1001001; len_a[0] = 7; det_a[0] = 32'b0001001;
        run_vec("overlap", 100);
        chk("det_ch_hold_0", 32'(det_ch), 32'd0);

        // Interleave ch0 1001 (detects) with ch1 1000 (never detects).
        do_reset();
        clear_vec();
        seq_a[0] = 32'b1001; len_a[0] = 4; det_a[0] = 32'b0001;
        seq_a[1] = 32'b1000; len_a[1] = 4; det_a[1] = 32'b0000;
        run_vec("interleave", 100);

        // Fairness: all four accept together, released one per cycle in order 0..3.
        do_reset();
        @(negedge clk);
        in_valid = 4'b1111;
        in_bit   = 4'b0000;
        @(negedge clk);
        in_valid = '0;
        chk("fair_accept", 32'(in_ready), 32'b0000);
        @(negedge clk);
        chk("fair_g0", 32'(in_ready), 32'b0001);
        @(negedge clk);
        chk("fair_g1", 32'(in_ready), 32'b0011);
        @(negedge clk);
        chk("fair_g2", 32'(in_ready), 32'b0111);
        @(negedge clk);
        chk("fair_g3", 32'(in_ready), 32'b1111);
        in_valid = 4'b1010;
        @(negedge clk);
        in_valid = '0;
        chk("fair2_accept", 32'(in_ready), 32'b0101);
        @(negedge clk);
        chk("fair2_g1", 32'(in_ready), 32'b0111);
        @(negedge clk);
        chk("fair2_g3", 32'(in_ready), 32'b1111);
        drain_and_check("fair_pending_dets");

        // Clear mid-pattern on ch2; the 1 offered with the clear is discarded.
        do_reset();
        clear_vec();
        seq_a[2] = 32'b100; len_a[2] = 3; det_a[2] = 32'b000;
        run_vec("clr_pre", 100);
        @(negedge clk);
        chan_clr    = 4'b0100;
        in_valid[2] = 1'b1;
        in_bit[2]   = 1'b1;
        @(negedge clk);
        chan_clr = '0;
        in_valid = '0;
        chk("clr_discard_ready", 32'(in_ready[2]), 32'd1);
        clear_vec();
        seq_a[2] = 32'b001; len_a[2] = 3; det_a[2] = 32'b000;
        run_vec("clr_mid", 100);
        seq_a[2] = 32'b001; len_a[2] = 3; det_a[2] = 32'b001;
        run_vec("clr_post", 100);
        chk("det_ch_hold_2", 32'(det_ch), 32'd2);

        // Clear on ch3 in the same cycle its 4th bit (1) is granted.
        do_reset();
        clear_vec();
        seq_a[3] = 32'b100; len_a[3] = 3; det_a[3] = 32'b000;
        run_vec("coll_pre", 100);
        @(negedge clk);
        in_valid[3] = 1'b1;
        in_bit[3]   = 1'b1;
        @(negedge clk);
        in_valid = '0;
        chk("coll_accepted", 32'(in_ready[3]), 32'd0);
        chan_clr = 4'b1000;
        @(negedge clk);
        chan_clr = '0;
        chk("coll_pend_cleared", 32'(in_ready[3]), 32'd1);
        // From S0 a fresh 1001 detects only on its last bit.
        clear_vec();
        seq_a[3] = 32'b1001; len_a[3] = 4; det_a[3] = 32'b0001;
        run_vec("coll_post", 100);

        // Reset with ch1 in S3 and a pending 1 must drop both.
        do_reset();
        clear_vec();
        seq_a[1] = 32'b100; len_a[1] = 3; det_a[1] = 32'b000;
        run_vec("rst_pre", 100);
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_bit[1]   = 1'b1;
        @(negedge clk);
        in_valid = '0;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_det_valid", 32'(det_valid), 32'd0);
        reset = 1'b0;
        clear_vec();
        seq_a[1] = 32'b1; len_a[1] = 1; det_a[1] = 32'b0;
        run_vec("rst_post", 100);

`ifdef SEQDET_SCHED_CNT_EN
        // 300 detections on ch3 saturate its counter at 255.
        do_reset();
        clear_vec();
        seq_a[3] = 32'b1001; len_a[3] = 4; det_a[3] = 32'b0001;
        run_vec("cnt_first", 100);
        seq_a[3] = 32'b001; len_a[3] = 3; det_a[3] = 32'b001;
        for (int n = 0; n < 299; n++) run_vec("cnt_loop", 100);
        for (int s = 0; s < NCH; s++) begin
            cnt_sel = CW'(s);
            #1;
            chk("cnt_out", 32'(cnt_out), (s == 3) ? 32'd255 : 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
